// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Connects the CPU load/store path to a single-port memory that uses a
// valid/grant handshake. A request is accepted only while the unit is idle.
// The unit then does one of two things:
//   - A misaligned or illegal request completes right away with resp_err=1.
//     It never reaches memory.
//   - A legal request drives one memory transaction. Loads then wait for
//     mem_rvalid, and the returned word is shifted and extended.
// Every accepted request ends with a one-cycle resp_valid pulse, unless rst
// abandons it.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   CPU request handshake (ready == idle)
//   req_write             1 = store, 0 = load
//   maskmode              00 byte, 01 half, 10 word, 11 illegal
//   sext                  sign-extend (1) or zero-extend (0) load results
//   address, write_data   byte address and right-aligned store data
//   resp_valid, resp_err  completion pulse and misaligned/illegal flag
//   read_data             extended load result, held between responses
//   busy                  request in flight (PC stall)
//   mem_req, mem_we       memory request strobe and write enable
//   mem_addr              word-aligned memory address
//   mem_be, mem_wdata     byte enables and lane-replicated store data
//   mem_gnt, mem_rvalid   memory grant and read-data valid
//   mem_rdata             memory read word
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            maskmode,
  input  logic                  sext,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsuState_t;

  lsuState_t state;

  // Request fields captured on acceptance. Only the low address bits are
  // kept here, because mem_addr already holds the word part of the address.
  logic       reqWrite;
  logic [1:0] reqMask;
  logic       reqSext;
  logic [1:0] reqAddrLo;

  logic                  misaligned;
  logic [3:0]            beNext;
  logic [DATA_WIDTH-1:0] wdataNext;
  logic [DATA_WIDTH-1:0] loadShifted;
  logic [DATA_WIDTH-1:0] loadExt;

  // Alignment check, byte enables and lane-replicated store data for the
  // request currently on the CPU inputs. These are evaluated while idle and
  // latched into the memory-side registers when the request is accepted.
  always_comb begin
    misaligned = 1'b0;
    beNext     = 4'b1111;
    wdataNext  = write_data;
    case (maskmode)
      2'b00: begin
        beNext    = 4'b0001 << address[1:0];
        wdataNext = {4{write_data[7:0]}};
      end
      2'b01: begin
        misaligned = address[0];
        beNext     = 4'b0011 << address[1:0];
        wdataNext  = {2{write_data[15:0]}};
      end
      2'b10: begin
        misaligned = (address[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // The addressed lane is moved down to bit 0, truncated to the access
  // size, then extended. Illegal sizes never reach memory, so the default
  // arm only has to handle word loads.
  always_comb begin
    loadShifted = mem_rdata >> {reqAddrLo, 3'b000};
    loadExt     = mem_rdata;
    case (reqMask)
      2'b00: loadExt = {{(DATA_WIDTH-8){reqSext & loadShifted[7]}}, loadShifted[7:0]};
      2'b01: loadExt = {{(DATA_WIDTH-16){reqSext & loadShifted[15]}}, loadShifted[15:0]};
      default: loadExt = mem_rdata;
    endcase
  end

  // Main FSM. All outputs are registered, so each output changes on the same
  // edge as the state it belongs to. mem_req, mem_we and mem_be are set on
  // entry to REQ and cleared on the grant; they are never high in any other
  // state. mem_addr and mem_wdata stay at their last value, so they are
  // stable during REQ. resp_err and read_data change only on entry to RESP
  // and hold their value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      read_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      reqWrite   <= 1'b0;
      reqMask    <= 2'b00;
      reqSext    <= 1'b0;
      reqAddrLo  <= 2'b00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            reqWrite  <= req_write;
            reqMask   <= maskmode;
            reqSext   <= sext;
            reqAddrLo <= address[1:0];
            mem_addr  <= {address[DATA_WIDTH-1:2], 2'b00};
            mem_wdata <= wdataNext;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
              mem_we  <= req_write;
              mem_be  <= beNext;
            end
          end
        end

        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            if (reqWrite) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
            end else begin
              state <= WAIT_R;
            end
          end
        end

        WAIT_R: begin
          if (mem_rvalid) begin
            state      <= RESP;
            read_data  <= loadExt;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end
        end

        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed testbench for load_store_unit. The memory handshake is driven
// cycle by cycle, and every expected value is computed by hand.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  maskmode;
  logic        sext;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] read_data;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks;
  int errors;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .maskmode   (maskmode),
    .sext       (sext),
    .address    (address),
    .write_data (write_data),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .read_data  (read_data),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends, even if the design stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [1:0] mask, input logic sx,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = valid;
    req_write  = write;
    maskmode   = mask;
    sext       = sx;
    address    = addr;
    write_data = wdata;
  endtask

  // Runs one legal access with the grant and rvalid on the first eligible
  // cycle. A junk rvalid is also driven while the unit is idle and in REQ;
  // it must have no effect on read_data.
  task automatic bestCase(input string tag, input logic write, input logic [1:0] mask,
                          input logic sx, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [3:0] expBe,
                          input logic [31:0] expWdata, input logic [31:0] expRead);
    applyStimulus(1'b1, write, mask, sx, addr, wdata);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    step();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, "_memreq"}, {31'b0, mem_req}, 32'd1);
    checkOutput({tag, "_memwe"}, {31'b0, mem_we}, {31'b0, write});
    checkOutput({tag, "_be"}, {28'b0, mem_be}, {28'b0, expBe});
    checkOutput({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    checkOutput({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
    if (write) checkOutput({tag, "_wdata"}, mem_wdata, expWdata);
    step();
    if (!write) begin
      checkOutput({tag, "_waitvalid"}, {31'b0, resp_valid}, 32'd0);
      checkOutput({tag, "_waitreq"}, {31'b0, mem_req}, 32'd0);
      mem_rdata = rdata;
      step();
    end
    checkOutput({tag, "_resp"}, {31'b0, resp_valid}, 32'd1);
    checkOutput({tag, "_err"}, {31'b0, resp_err}, 32'd0);
    checkOutput({tag, "_rdata"}, read_data, expRead);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    step();
    checkOutput({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    checkOutput({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  // A misaligned or illegal request completes one cycle after acceptance with
  // resp_err set. It never raises mem_req, and read_data keeps its value.
  task automatic misalignedCase(input string tag, input logic [1:0] mask,
                                input logic [31:0] addr, input logic [31:0] holdRead);
    applyStimulus(1'b1, 1'b0, mask, 1'b1, addr, 32'h0);
    mem_gnt = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, "_resp"}, {31'b0, resp_valid}, 32'd1);
    checkOutput({tag, "_err"}, {31'b0, resp_err}, 32'd1);
    checkOutput({tag, "_memreq"}, {31'b0, mem_req}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
    checkOutput({tag, "_rdata"}, read_data, holdRead);
    step();
    checkOutput({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    checkOutput({tag, "_errhold"}, {31'b0, resp_err}, 32'd1);
    checkOutput({tag, "_memreq2"}, {31'b0, mem_req}, 32'd0);
    checkOutput({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
    mem_gnt = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Reset values
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_resp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_err", {31'b0, resp_err}, 32'd0);
    checkOutput("rst_rdata", read_data, 32'h0);
    checkOutput("rst_memreq", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_memwe", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_be", {28'b0, mem_be}, 32'h0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    step();

    // Best-case loads
    bestCase("ldh_s", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80011234, 4'b1100, 32'h0, 32'hFFFF8001);
    bestCase("ldh_z", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80011234, 4'b1100, 32'h0, 32'h00008001);
    bestCase("ldb1_s", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h12348056, 4'b0010, 32'h0, 32'hFFFFFF80);
    bestCase("ldb3_z", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hF0123456, 4'b1000, 32'h0, 32'h000000F0);
    bestCase("ldb0_s", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 32'h0000007F, 4'b0001, 32'h0, 32'h0000007F);
    bestCase("ldh0_s", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h12347FFF, 4'b0011, 32'h0, 32'h00007FFF);
    bestCase("ldw", 1'b0, 2'b10, 1'b1, 32'h204, 32'h0, 32'hCAFEBABE, 4'b1111, 32'h0, 32'hCAFEBABE);

    // Misaligned and illegal requests
    misalignedCase("mis_w6", 2'b10, 32'h006, 32'hCAFEBABE);
    misalignedCase("mis_w2", 2'b10, 32'h002, 32'hCAFEBABE);
    misalignedCase("mis_h1", 2'b01, 32'h101, 32'hCAFEBABE);
    misalignedCase("ill_11", 2'b11, 32'h100, 32'hCAFEBABE);

    // Stores; read_data must keep the last load result
    bestCase("stb", 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 32'h0, 4'b1000, 32'hABABABAB, 32'hCAFEBABE);
    bestCase("sth", 1'b1, 2'b01, 1'b0, 32'h002, 32'h1234BEEF, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'hCAFEBABE);
    bestCase("stw", 1'b1, 2'b10, 1'b0, 32'h008, 32'h01234567, 32'h0, 4'b1111, 32'h01234567, 32'hCAFEBABE);

    // Grant held off for 3 cycles, then rvalid 2 cycles after the grant
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_memreq", {31'b0, mem_req}, 32'd1);
      checkOutput("stall_addr", mem_addr, 32'h200);
      checkOutput("stall_be", {28'b0, mem_be}, 32'hF);
      checkOutput("stall_we", {31'b0, mem_we}, 32'd0);
      checkOutput("stall_busy", {31'b0, busy}, 32'd1);
      checkOutput("stall_resp", {31'b0, resp_valid}, 32'd0);
      step();
    end
    checkOutput("stall_memreq4", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("stall_wait_busy", {31'b0, busy}, 32'd1);
    checkOutput("stall_wait_req", {31'b0, mem_req}, 32'd0);
    step();
    checkOutput("stall_wait2_busy", {31'b0, busy}, 32'd1);
    checkOutput("stall_wait2_resp", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA33CC;
    step();
    mem_rvalid = 1'b0;
    checkOutput("stall_resp_pulse", {31'b0, resp_valid}, 32'd1);
    checkOutput("stall_rdata", read_data, 32'h55AA33CC);
    step();
    checkOutput("stall_single", {31'b0, resp_valid}, 32'd0);
    checkOutput("stall_idle_busy", {31'b0, busy}, 32'd0);

    // Reset during WAIT_R, then a stale rvalid
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    mem_gnt = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    mem_gnt = 1'b0;
    checkOutput("rstw_waiting", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h13579BDF;
    checkOutput("rstw_ready", {31'b0, req_ready}, 32'd1);
    step();
    mem_rvalid = 1'b0;
    checkOutput("rstw_noresp", {31'b0, resp_valid}, 32'd0);
    checkOutput("rstw_busy", {31'b0, busy}, 32'd0);
    checkOutput("rstw_ready2", {31'b0, req_ready}, 32'd1);
    checkOutput("rstw_rdata", read_data, 32'h0);
    step();
    checkOutput("rstw_noresp2", {31'b0, resp_valid}, 32'd0);

    // Reset during REQ drops mem_req
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h11111111);
    step();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("rstq_memreq", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstq_memreq0", {31'b0, mem_req}, 32'd0);
    checkOutput("rstq_ready", {31'b0, req_ready}, 32'd1);
    step();

    // Back-to-back stores with req_valid held high and the grant always up
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h010, 32'hA5A5A5A5);
    mem_gnt = 1'b1;
    step();
    checkOutput("b2b_req1", {31'b0, mem_req}, 32'd1);
    checkOutput("b2b_ready1", {31'b0, req_ready}, 32'd0);
    step();
    checkOutput("b2b_resp1", {31'b0, resp_valid}, 32'd1);
    checkOutput("b2b_ready_resp", {31'b0, req_ready}, 32'd0);
    checkOutput("b2b_memreq_resp", {31'b0, mem_req}, 32'd0);
    step();
    checkOutput("b2b_ready_idle", {31'b0, req_ready}, 32'd1);
    checkOutput("b2b_memreq_idle", {31'b0, mem_req}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b_req2", {31'b0, mem_req}, 32'd1);
    checkOutput("b2b_ready2", {31'b0, req_ready}, 32'd0);
    step();
    checkOutput("b2b_resp2", {31'b0, resp_valid}, 32'd1);
    mem_gnt = 1'b0;
    step();
    checkOutput("b2b_end", {31'b0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data and address paths; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  the CPU presents a load/store request.
REQ-005 req_ready  output  1  the unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 maskmode  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 sext  input  1  load result is sign-extended (1) or zero-extended (0).
REQ-009 address  input  32  byte address from the ALU.
REQ-010 write_data  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_err  output  1  the completed access was misaligned or illegal; qualified by resp_valid.
REQ-013 read_data  output  32  extended load result; qualified by resp_valid with req_write=0.
REQ-014 busy  output  1  request in flight; CPU PC-stall signal.
REQ-015 mem_req, mem_we  output  1,1  memory request strobe and write enable.
REQ-016 mem_addr  output  32  word address, with bits [1:0] forced to 00.
REQ-017 mem_be, mem_wdata  output  4,32  byte enables and lane-replicated store data.
REQ-018 mem_gnt, mem_rvalid  input  1,1  memory request accepted; memory read data valid.
REQ-019 mem_rdata  input  32  memory read word.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT_R and RESP.
REQ-021 req_ready SHALL be high exactly when the state is IDLE.
REQ-022 busy SHALL be high in every state other than IDLE.
REQ-023 Acceptance is req_valid and req_ready both high; on acceptance the unit SHALL register req_write, maskmode, sext, address and write_data.
REQ-024 The unit SHALL flag an accepted request as misaligned when any of these holds: maskmode=01 with address[0]=1; maskmode=10 with address[1:0]!=00; maskmode=11.
REQ-025 On acceptance the FSM SHALL go to RESP if the request is misaligned, and to REQ otherwise.
REQ-026 A misaligned request SHALL never assert mem_req.
REQ-027 In REQ, mem_req SHALL be 1 and mem_addr, mem_we, mem_be and mem_wdata SHALL hold constant until mem_gnt=1.
REQ-028 On mem_gnt in REQ, a store SHALL go to RESP and a load SHALL go to WAIT_R.
REQ-029 mem_rvalid SHALL be ignored outside WAIT_R; the earliest mem_rvalid that counts is the cycle after the grant.
REQ-030 In WAIT_R, on mem_rvalid the unit SHALL register the extracted data and go to RESP.
REQ-031 RESP SHALL last exactly one cycle, with resp_valid=1, and then return to IDLE.
REQ-032 Best-case latency from acceptance to resp_valid SHALL be 2 cycles for a store and 3 cycles for a load (grant and rvalid each on the first eligible cycle).
REQ-033 mem_be SHALL be 0001<<address[1:0] for a byte access, 0011<<address[1:0] for a half access, and 1111 for a word access.
REQ-034 mem_wdata SHALL be the low byte replicated 4 times for a byte store, the low half replicated twice for a half store, and write_data unchanged for a word store.
REQ-035 Load data SHALL be extracted as mem_rdata >> (8*address[1:0]), truncated to 8 or 16 bits and then sign- or zero-extended to 32 bits per sext; a word load is passed through unchanged.
REQ-036 read_data and resp_err SHALL hold their last values outside RESP.
REQ-037 resp_err SHALL be 0 for every access that reached memory.
REQ-038 mem_req, mem_we and mem_be SHALL be 0 whenever the state is not REQ.

Reset
REQ-039 While rst=1 on a rising edge, the next state SHALL be IDLE regardless of the current state, including REQ and WAIT_R; any in-flight access is abandoned with no response.
REQ-040 Reset values SHALL be: req_ready=1, busy=0, resp_valid=0, resp_err=0, read_data=0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0.
REQ-041 A mem_rvalid that arrives after reset for an abandoned load SHALL be ignored.

Verification
REQ-042 Store of 0x000000AB as a byte to 0x103, with the grant on the first cycle -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x100, resp_valid 2 cycles after acceptance with resp_err=0.
REQ-043 Load of a half from 0x102, mem_rdata=0x8001_1234, sext=1 -> read_data=0xFFFF8001; the same load with sext=0 -> read_data=0x00008001.
REQ-044 Word load from 0x006 -> mem_req never asserted, resp_valid with resp_err=1 one cycle after acceptance.
REQ-045 Word load from 0x200 with mem_gnt held low for 3 cycles and mem_rvalid 2 cycles after the grant -> request fields stable throughout, busy=1 throughout, a single resp_valid pulse.
REQ-046 rst asserted during WAIT_R, then mem_rvalid arrives -> state IDLE, no resp_valid, req_ready=1 on the cycle after reset is released.
REQ-047 Back-to-back requests with req_valid held high -> the second request is accepted only on the cycle after RESP (req_ready low while busy).
